// File: rtl/load_stream_tx_pkg.sv
// Shared types and constants for the engine load stream transmitter.
package load_stream_tx_pkg;

    localparam int unsigned DEF_NUM_ENGINE = 4;
    localparam int unsigned LIT_IDX_MAX    = 4;

    typedef struct packed {
        logic [15:0] lit_a;
        logic [15:0] lit_b;
    } node_t;

    typedef struct packed {
        logic [3:0]  tag;
        logic [15:0] ptr;
    } dummy_entry_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DESC   = 3'd1,
        ST_CHG    = 3'd2,
        ST_CLAUSE = 3'd3,
        ST_PTR    = 3'd4,
        ST_FIN    = 3'd5
    } ld_state_e;

endpackage

// File: rtl/ld_addr_cnt.sv
// Loadable, enabled up-counter that wraps at 2^W; load wins over enable.
module ld_addr_cnt #(
    parameter int unsigned W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/load_stream_tx.sv
// Streams clause and pointer words for a set of engines, one descriptor per engine,
// with a change-engine strobe ahead of every engine after the first.
module load_stream_tx
    import load_stream_tx_pkg::*;
#(
    parameter int unsigned NUM_ENGINE     = DEF_NUM_ENGINE,
    parameter int unsigned PTR_PER_ENGINE = 2 * LIT_IDX_MAX + 1,
    parameter int unsigned CLAUSE_AW      = 12,
    parameter int unsigned PTR_AW         = 10
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    input  logic [$clog2(NUM_ENGINE):0]   num_engines,
    input  logic                          desc_valid,
    output logic                          desc_ready,
    input  logic [CLAUSE_AW:0]            desc_clause_cnt,
    output logic                          clause_rd_en,
    output logic [CLAUSE_AW-1:0]          clause_rd_addr,
    input  node_t                         clause_rd_data,
    output logic                          ptr_rd_en,
    output logic [PTR_AW-1:0]             ptr_rd_addr,
    input  dummy_entry_t                  ptr_rd_data,
    output node_t                         clause_out,
    output dummy_entry_t                  ptr_out,
    output logic                          load_clause_out,
    output logic                          load_ptr_out,
    output logic                          load_change_engine_out,
    output logic                          busy,
    output logic                          done
);

    localparam int unsigned NE_W   = $clog2(NUM_ENGINE) + 1;
    localparam int unsigned PCNT_W = $clog2(PTR_PER_ENGINE + 1);
    localparam int unsigned REM_W  = (CLAUSE_AW + 1 > PCNT_W) ? CLAUSE_AW + 1 : PCNT_W;

    ld_state_e        state_q, state_d;
    logic [NE_W-1:0]  num_eng_q, num_eng_d;
    logic [NE_W-1:0]  eng_idx_q, eng_idx_d;
    logic [REM_W-1:0] rem_q, rem_d;
    logic             addr_clr;
    logic             clause_adv;
    logic             ptr_adv;

    // Next-state, read-countdown and address-counter control.
    always_comb begin
        state_d    = state_q;
        num_eng_d  = num_eng_q;
        eng_idx_d  = eng_idx_q;
        rem_d      = rem_q;
        addr_clr   = 1'b0;
        clause_adv = 1'b0;
        ptr_adv    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_clr  = 1'b1;
                    eng_idx_d = '0;
                    num_eng_d = (num_engines > NE_W'(NUM_ENGINE)) ? NE_W'(NUM_ENGINE) : num_engines;
                    state_d   = (num_engines == '0) ? ST_FIN : ST_DESC;
                end
            end
            ST_DESC: begin
                if (desc_valid && desc_ready) begin
                    rem_d = REM_W'(desc_clause_cnt);
                    if (eng_idx_q != '0) begin
                        state_d = ST_CHG;
                    end else if (desc_clause_cnt == '0) begin
                        state_d = ST_PTR;
                        rem_d   = REM_W'(PTR_PER_ENGINE);
                    end else begin
                        state_d = ST_CLAUSE;
                    end
                end
            end
            ST_CHG: begin
                if (rem_q == '0) begin
                    state_d = ST_PTR;
                    rem_d   = REM_W'(PTR_PER_ENGINE);
                end else begin
                    state_d = ST_CLAUSE;
                end
            end
            ST_CLAUSE: begin
                clause_adv = 1'b1;
                rem_d      = rem_q - REM_W'(1);
                if (rem_q == REM_W'(1)) begin
                    state_d = ST_PTR;
                    rem_d   = REM_W'(PTR_PER_ENGINE);
                end
            end
            ST_PTR: begin
                ptr_adv = 1'b1;
                rem_d   = rem_q - REM_W'(1);
                if (rem_q == REM_W'(1)) begin
                    eng_idx_d = eng_idx_q + NE_W'(1);
                    state_d   = ((eng_idx_q + NE_W'(1)) == num_eng_q) ? ST_FIN : ST_DESC;
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State, counters and every strobe are registered; strobes decode the next state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q                <= ST_IDLE;
            num_eng_q              <= '0;
            eng_idx_q              <= '0;
            rem_q                  <= '0;
            desc_ready             <= 1'b0;
            clause_rd_en           <= 1'b0;
            ptr_rd_en              <= 1'b0;
            busy                   <= 1'b0;
            done                   <= 1'b0;
            load_clause_out        <= 1'b0;
            load_ptr_out           <= 1'b0;
            load_change_engine_out <= 1'b0;
        end else begin
            state_q                <= state_d;
            num_eng_q              <= num_eng_d;
            eng_idx_q              <= eng_idx_d;
            rem_q                  <= rem_d;
            desc_ready             <= (state_d == ST_DESC);
            clause_rd_en           <= (state_d == ST_CLAUSE);
            ptr_rd_en              <= (state_d == ST_PTR);
            busy                   <= (state_d != ST_IDLE);
            done                   <= (state_d == ST_FIN);
            load_clause_out        <= clause_rd_en;
            load_ptr_out           <= ptr_rd_en;
            load_change_engine_out <= (state_q == ST_CHG);
        end
    end

    ld_addr_cnt #(.W(CLAUSE_AW)) u_clause_addr (
        .clock    (clock),
        .reset    (reset),
        .load     (addr_clr),
        .load_val (CLAUSE_AW'(0)),
        .en       (clause_adv),
        .cnt      (clause_rd_addr)
    );

    ld_addr_cnt #(.W(PTR_AW)) u_ptr_addr (
        .clock    (clock),
        .reset    (reset),
        .load     (addr_clr),
        .load_val (PTR_AW'(0)),
        .en       (ptr_adv),
        .cnt      (ptr_rd_addr)
    );

    // Memory data lands in the same cycle as the delayed strobe, so it is gated here.
    assign clause_out = load_clause_out ? clause_rd_data : '0;
    assign ptr_out    = load_ptr_out    ? ptr_rd_data    : '0;

endmodule

// File: tb/tb_load_stream_tx.sv
// Directed, table-driven bench for load_stream_tx with small address spaces to exercise wrap.
module tb_load_stream_tx;
    import load_stream_tx_pkg::*;

    localparam int unsigned NE  = 4;
    localparam int unsigned PPE = 9;
    localparam int unsigned CAW = 3;
    localparam int unsigned PAW = 5;

    logic               clock;
    logic               reset;
    logic               start;
    logic [2:0]         num_engines;
    logic               desc_valid;
    logic               desc_ready;
    logic [CAW:0]       desc_clause_cnt;
    logic               clause_rd_en;
    logic [CAW-1:0]     clause_rd_addr;
    node_t              clause_rd_data;
    logic               ptr_rd_en;
    logic [PAW-1:0]     ptr_rd_addr;
    dummy_entry_t       ptr_rd_data;
    node_t              clause_out;
    dummy_entry_t       ptr_out;
    logic               load_clause_out;
    logic               load_ptr_out;
    logic               load_change_engine_out;
    logic               busy;
    logic               done;

    load_stream_tx #(
        .NUM_ENGINE(NE), .PTR_PER_ENGINE(PPE), .CLAUSE_AW(CAW), .PTR_AW(PAW)
    ) dut (
        .clock                  (clock),
        .reset                  (reset),
        .start                  (start),
        .num_engines            (num_engines),
        .desc_valid             (desc_valid),
        .desc_ready             (desc_ready),
        .desc_clause_cnt        (desc_clause_cnt),
        .clause_rd_en           (clause_rd_en),
        .clause_rd_addr         (clause_rd_addr),
        .clause_rd_data         (clause_rd_data),
        .ptr_rd_en              (ptr_rd_en),
        .ptr_rd_addr            (ptr_rd_addr),
        .ptr_rd_data            (ptr_rd_data),
        .clause_out             (clause_out),
        .ptr_out                (ptr_out),
        .load_clause_out        (load_clause_out),
        .load_ptr_out           (load_ptr_out),
        .load_change_engine_out (load_change_engine_out),
        .busy                   (busy),
        .done                   (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic node_t clause_pat(input int i);
        node_t n;
        n.lit_a = 16'hC1A0;
        n.lit_b = 16'(i % (1 << CAW));
        return n;
    endfunction

    function automatic dummy_entry_t ptr_pat(input int i);
        dummy_entry_t d;
        d.tag = 4'h5;
        d.ptr = 16'(i % (1 << PAW));
        return d;
    endfunction

    // Memories with one-cycle read latency; contents encode the address.
    always @(posedge clock) begin
        clause_rd_data <= clause_rd_en ? clause_pat(int'(clause_rd_addr)) : '0;
        ptr_rd_data    <= ptr_rd_en    ? ptr_pat(int'(ptr_rd_addr))       : '0;
    end

    node_t        clause_log[$];
    dummy_entry_t ptr_log[$];
    int           chg_cl_pos[$];
    int           chg_pt_pos[$];
    int           overlap_tot = 0;
    int           strobe_tot  = 0;
    int           done_tot    = 0;

    always @(negedge clock) begin
        if (load_change_engine_out) begin
            chg_cl_pos.push_back(clause_log.size());
            chg_pt_pos.push_back(ptr_log.size());
        end
        if (load_clause_out) clause_log.push_back(clause_out);
        if (load_ptr_out) ptr_log.push_back(ptr_out);
        if (load_clause_out && load_ptr_out) overlap_tot++;
        if (load_clause_out || load_ptr_out || load_change_engine_out) strobe_tot++;
        if (done) done_tot++;
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    typedef struct {
        string name;
        int    ne;
        int    c0, c1, c2, c3;
        int    stall;
        int    restart;
        int    exp_cl, exp_pt, exp_ch, exp_cbc, exp_pbc;
    } vec_t;

    function automatic int vcnt(input vec_t v, input int k);
        case (k)
            0:       return v.c0;
            1:       return v.c1;
            2:       return v.c2;
            3:       return v.c3;
            default: return 0;
        endcase
    endfunction

    task automatic give_desc(input int cnt);
        int t = 0;
        while (!desc_ready && t < 200) begin
            @(negedge clock);
            t++;
        end
        chk("give_desc.ready", 64'(desc_ready), 64'd1);
        desc_valid      = 1'b1;
        desc_clause_cnt = 4'(cnt);
        @(negedge clock);
        desc_valid      = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int  c0, p0, h0, d0, o0, k, cyc, s0, cl, pt, ch, cbc, pbc, err;
        bit  seen;
        c0 = clause_log.size();
        p0 = ptr_log.size();
        h0 = chg_cl_pos.size();
        d0 = done_tot;
        o0 = overlap_tot;
        @(negedge clock);
        start = 1'b1;
        num_engines = 3'(v.ne);
        @(negedge clock);
        start = 1'b0;
        k = 0;
        cyc = 0;
        seen = 1'b0;
        while (!seen && cyc < 3000) begin
            if (done) begin
                seen = 1'b1;
            end else if (desc_ready) begin
                if (k == 1 && v.stall > 0) begin
                    #1;
                    s0 = strobe_tot;
                    repeat (v.stall) @(negedge clock);
                    #1;
                    chk($sformatf("%s.stall_strobes", v.name), 64'(strobe_tot - s0), 64'd0);
                    chk($sformatf("%s.stall_ready", v.name), 64'(desc_ready), 64'd1);
                end
                desc_valid      = 1'b1;
                desc_clause_cnt = 4'(vcnt(v, k));
                k++;
                @(negedge clock);
                desc_valid = 1'b0;
                cyc++;
                if (v.restart != 0 && k == 1) begin
                    start = 1'b1;
                    num_engines = 3'd2;
                    @(negedge clock);
                    start = 1'b0;
                    cyc++;
                end
            end else begin
                @(negedge clock);
                cyc++;
            end
        end
        chk($sformatf("%s.done_seen", v.name), 64'(seen), 64'd1);
        if (v.ne == 0) chk($sformatf("%s.latency", v.name), 64'(cyc), 64'd0);
        repeat (3) @(negedge clock);
        #1;
        cl  = clause_log.size() - c0;
        pt  = ptr_log.size() - p0;
        ch  = chg_cl_pos.size() - h0;
        cbc = (ch > 0) ? chg_cl_pos[h0] - c0 : -1;
        pbc = (ch > 0) ? chg_pt_pos[h0] - p0 : -1;
        err = 0;
        for (int i = 0; i < cl; i++) if (clause_log[c0 + i] !== clause_pat(i)) err++;
        for (int i = 0; i < pt; i++) if (ptr_log[p0 + i] !== ptr_pat(i)) err++;
        chk($sformatf("%s.clauses", v.name), 64'(cl), 64'(v.exp_cl));
        chk($sformatf("%s.ptrs", v.name), 64'(pt), 64'(v.exp_pt));
        chk($sformatf("%s.changes", v.name), 64'(ch), 64'(v.exp_ch));
        chk($sformatf("%s.data_errs", v.name), 64'(err), 64'd0);
        chk($sformatf("%s.dones", v.name), 64'(done_tot - d0), 64'd1);
        chk($sformatf("%s.overlap", v.name), 64'(overlap_tot - o0), 64'd0);
        chk($sformatf("%s.idle", v.name), 64'({busy, done, desc_ready}), 64'd0);
        if (v.exp_ch > 0) begin
            chk($sformatf("%s.cl_before_chg", v.name), 64'(cbc), 64'(v.exp_cbc));
            chk($sformatf("%s.pt_before_chg", v.name), 64'(pbc), 64'(v.exp_pbc));
        end
    endtask

    task automatic chk_all_zero(input string nm);
        chk($sformatf("%s.strobes", nm),
            64'({busy, done, desc_ready, clause_rd_en, ptr_rd_en,
                 load_clause_out, load_ptr_out, load_change_engine_out}), 64'd0);
        chk($sformatf("%s.outs", nm), 64'({clause_out, ptr_out}), 64'd0);
        chk($sformatf("%s.addrs", nm), 64'({clause_rd_addr, ptr_rd_addr}), 64'd0);
    endtask

    vec_t vecs[8];

    initial begin
        int p0, t, s0, d0;
        vecs[0] = '{"one_eng",  1, 3, 0, 0, 0, 0, 0,  3,  9, 0, -1, -1};
        vecs[1] = '{"two_eng",  2, 2, 4, 0, 0, 5, 0,  6, 18, 1,  2,  9};
        vecs[2] = '{"zero_cl",  2, 3, 0, 0, 0, 0, 0,  3, 18, 1,  3,  9};
        vecs[3] = '{"three",    3, 1, 1, 1, 0, 0, 0,  3, 27, 2,  1,  9};
        vecs[4] = '{"clamp",    7, 1, 1, 1, 1, 0, 0,  4, 36, 3,  1,  9};
        vecs[5] = '{"wrap_cl",  2, 5, 6, 0, 0, 0, 0, 11, 18, 1,  5,  9};
        vecs[6] = '{"restart",  1, 3, 0, 0, 0, 0, 1,  3,  9, 0, -1, -1};
        vecs[7] = '{"none",     0, 0, 0, 0, 0, 0, 0,  0,  0, 0, -1, -1};

        reset = 1'b1;
        start = 1'b0;
        num_engines = '0;
        desc_valid = 1'b0;
        desc_clause_cnt = '0;
        #1 reset = 1'b0;
        #2;
        chk_all_zero("reset");
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Reset asserted while the fourth pointer read is on the bus.
        p0 = ptr_log.size();
        @(negedge clock);
        start = 1'b1;
        num_engines = 3'd1;
        @(negedge clock);
        start = 1'b0;
        give_desc(3);
        t = 0;
        while ((ptr_log.size() - p0) < 3 && t < 500) begin
            @(negedge clock);
            #1;
            t++;
        end
        chk("midrst.reach", 64'(ptr_log.size() - p0), 64'd3);
        chk("midrst.ptr_rd_en", 64'(ptr_rd_en), 64'd1);
        reset = 1'b0;
        #1;
        chk_all_zero("midrst");
        s0 = strobe_tot;
        d0 = done_tot;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        #1;
        chk("midrst.no_strobes", 64'(strobe_tot - s0), 64'd0);
        chk("midrst.no_done", 64'(done_tot - d0), 64'd0);
        run_vec(vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
